mem: RTL and testbench
======================

# mem

Memory-access stage of the RISC-V pipeline, sitting between the ex_mem pipeline register and mem_wb. It performs LOAD/STORE through a byte-wide, single-port RAM with one-cycle read latency. A small state machine serializes each access into 1, 2 or 4 byte transfers and asserts a stall request to ctrl while the access is in progress. Non-memory instructions pass straight through.

## Interface
- ADDR_WIDTH, 32: memory address width.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the next rising edge of clk).
- aluop_i  in  7  opcode class from ex_mem (`LOAD`, `STORE`, others).
- alufunct3_i  in  3  access size/sign: `LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW`.
- me_i  in  1  memory access requested.
- maddr_i  in  ADDR_WIDTH  effective byte address.
- wreg_i / wd_i / wdata_i  in  1/5/32  register write enable, destination, and ALU result or store data.
- mem_din_i  in  8  RAM read data (byte addressed one cycle earlier).
- mem_a_o  out  ADDR_WIDTH  RAM byte address.
- mem_dout_o  out  8  RAM write data.
- mem_wr_o  out  1  RAM write strobe (1 = write).
- stall_req_o  out  1  to ctrl; hold pipeline while high.
- wreg_o / wd_o / wdata_o  out  1/5/32  to mem_wb.
- wreg_f / wd_f / wdata_f  out  1/5/32  forwarding to regfile.

## Operation
- Reset (rst==0): state IDLE. All outputs are 0, including mem_a_o, mem_dout_o, mem_wr_o, stall_req_o, and all wreg/wd/wdata outputs. Shift/result registers are cleared.
- N = 1/2/4 for B/H/W. Byte k is at maddr_i+k, little-endian. Addresses wrap modulo 2^ADDR_WIDTH. No alignment requirement.
- States:
  - **IDLE**: if me_i, then:
    - Drive mem_a_o=maddr_i combinationally.
    - For STORE, also drive mem_wr_o=1 and mem_dout_o=wdata_i[7:0].
    - Raise stall_req_o and latch the inputs.
    - Next state: ACCESS if N>1; otherwise WAIT (load) or DONE (store).
    - If not me_i: combinational pass-through wreg_o=wreg_i, wd_o=wd_i, wdata_o=wdata_i; stall_req_o=0.
  - **ACCESS**: issue byte k=1..N-1, one per cycle.
    - Load: capture the previous byte from mem_din_i.
    - Store: mem_dout_o = data[8k+7:8k].
    - After byte N-1: next state WAIT (load) or DONE (store).
  - **WAIT** (load only): capture the final byte. mem_wr_o=0. Next state DONE.
  - **DONE**: stall_req_o=0, mem_wr_o=0. Drive the latched wd.
    - Load: wreg_o=latched wreg; wdata_o = assembled value, sign-extended (LB/LH) or zero-extended (LBU/LHU).
    - Store: wreg_o=0, wdata_o=0.
    - Next state: IDLE.
- Contract with ctrl: the ex_mem register advances in the cycle stall_req_o drops, so DONE never re-sees the same access. The block itself does not re-check me_i in DONE.
- Forwarding:
  - wreg_f is 0 while stall_req_o=1 (load data not ready).
  - Otherwise wreg_f/wd_f/wdata_f equal wreg_o/wd_o/wdata_o.
- Unknown funct3 with me_i: treated as a word access.

## Timing
- Load of N bytes: stall_req_o high for N+1 cycles; result valid in DONE, cycle N+1 after acceptance.
- Store of N bytes: stall_req_o high for N cycles; DONE in cycle N.
- Non-memory instruction: zero added latency, stall_req_o never high.
- mem_wr_o is high only in cycles that issue a store byte. mem_a_o holds its last value when idle.
- Reset mid-operation: IDLE on the next edge; outputs are 0. Bytes already written stay written, and the partial load is discarded.
- Inputs are sampled only in IDLE. Changes to the inputs during ACCESS/WAIT are ignored.

## Configuration
- MEM_FORWARD_EN:
  - Defined: the wreg_f/wd_f/wdata_f forwarding path behaves as above.
  - Undefined: those ports are constant 0, and ctrl must stall on every MEM-stage hazard.
- All other behaviour is identical in both builds.

## Test plan
- LW at 0x100 with RAM[0x100..0x103]=78,56,34,12:
  - addresses 0x100..0x103 on consecutive cycles; stall_req_o high 5 cycles.
  - DONE: wreg_o=1, wdata_o=0x12345678.
- LB then LBU at an address holding 0x80: wdata_o=0xFFFFFF80, then 0x00000080; stall 2 cycles each.
- SH with wdata_i=0x1234ABCD at 0x201:
  - writes CD@0x201, then AB@0x202; stall 2 cycles.
  - DONE: wreg_o=0; RAM[0x203] unchanged.
- ADDI result 7 to x5 (me_i=0): same cycle wreg_o=1, wd_o=5, wdata_o=7; stall_req_o=0.
- LW at 0xFFFFFFFE: mem_a_o sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; result assembled correctly.
- rst=0 after 2 bytes of an SW: next cycle IDLE and all outputs 0; a following LW of the same address returns 2 new and 2 old bytes.

Source files
------------

// File: rtl/mem.sv
// mem: memory-access stage, serializes LOAD/STORE into byte transfers.
// Optional forwarding port enabled by defining MEM_FORWARD_EN.
module mem #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            aluop_i,
    input  logic [2:0]            alufunct3_i,
    input  logic                  me_i,
    input  logic [ADDR_WIDTH-1:0] maddr_i,
    input  logic                  wreg_i,
    input  logic [4:0]            wd_i,
    input  logic [31:0]           wdata_i,
    input  logic [7:0]            mem_din_i,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    output logic                  stall_req_o,
    output logic                  wreg_o,
    output logic [4:0]            wd_o,
    output logic [31:0]           wdata_o,
    output logic                  wreg_f,
    output logic [4:0]            wd_f,
    output logic [31:0]           wdata_f
);

    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            cnt_q, cnt_d, last_q, last_d;
    logic                  load_q, load_d, sign_q, sign_d, wreg_q, wreg_d;
    logic [4:0]            wd_q, wd_d;
    logic [31:0]           data_q, data_d;

    logic [1:0]            last_in;
    logic                  load_in;
    logic [ADDR_WIDTH-1:0] a_c;
    logic [7:0]            dout_c;
    logic                  wr_c, stall_c, wreg_c;
    logic [4:0]            wd_c;
    logic [31:0]           wdata_c;

    // Index of the last byte for the requested size; unknown sizes are words.
    always_comb begin
        last_in = 2'd3;
        unique case (alufunct3_i)
            3'b000, 3'b100: last_in = 2'd0;
            3'b001, 3'b101: last_in = 2'd1;
            default:        last_in = 2'd3;
        endcase
    end

    assign load_in = (aluop_i != OP_STORE);

    // Next-state and output logic of the byte-serializing FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        load_d  = load_q;
        sign_d  = sign_q;
        wreg_d  = wreg_q;
        wd_d    = wd_q;
        data_d  = data_q;
        a_c     = addr_q;
        dout_c  = 8'h00;
        wr_c    = 1'b0;
        stall_c = 1'b0;
        wreg_c  = 1'b0;
        wd_c    = 5'd0;
        wdata_c = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (me_i) begin
                    a_c     = maddr_i;
                    stall_c = 1'b1;
                    if (!load_in) begin
                        wr_c   = 1'b1;
                        dout_c = wdata_i[7:0];
                    end
                    load_d = load_in;
                    last_d = last_in;
                    sign_d = ~alufunct3_i[2];
                    wreg_d = wreg_i;
                    wd_d   = wd_i;
                    data_d = load_in ? 32'd0 : wdata_i;
                    cnt_d  = 2'd1;
                    if (last_in != 2'd0) begin
                        addr_d  = maddr_i + A_ONE;
                        state_d = ACCESS;
                    end else begin
                        addr_d  = maddr_i;
                        state_d = load_in ? WAIT : DONE;
                    end
                end else begin
                    wreg_c  = wreg_i;
                    wd_c    = wd_i;
                    wdata_c = wdata_i;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                if (load_q) begin
                    data_d[{cnt_q - 2'd1, 3'b000} +: 8] = mem_din_i;
                end else begin
                    wr_c   = 1'b1;
                    dout_c = data_q[{cnt_q, 3'b000} +: 8];
                end
                if (cnt_q == last_q) begin
                    state_d = load_q ? WAIT : DONE;
                end else begin
                    cnt_d  = cnt_q + 2'd1;
                    addr_d = addr_q + A_ONE;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                data_d[{last_q, 3'b000} +: 8] = mem_din_i;
                state_d = DONE;
            end
            DONE: begin
                wd_c = wd_q;
                if (load_q) begin
                    wreg_c = wreg_q;
                    unique case (last_q)
                        2'd0:    wdata_c = {{24{sign_q & data_q[7]}}, data_q[7:0]};
                        2'd1:    wdata_c = {{16{sign_q & data_q[15]}}, data_q[15:0]};
                        default: wdata_c = data_q;
                    endcase
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-access registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            load_q  <= 1'b0;
            sign_q  <= 1'b0;
            wreg_q  <= 1'b0;
            wd_q    <= 5'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            load_q  <= load_d;
            sign_q  <= sign_d;
            wreg_q  <= wreg_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
        end
    end

    // Outputs forced low while reset is asserted, so no stray write escapes.
    always_comb begin
        mem_a_o     = rst ? a_c : '0;
        mem_dout_o  = rst ? dout_c : 8'h00;
        mem_wr_o    = rst & wr_c;
        stall_req_o = rst & stall_c;
        wreg_o      = rst & wreg_c;
        wd_o        = rst ? wd_c : 5'd0;
        wdata_o     = rst ? wdata_c : 32'd0;
    end

`ifdef MEM_FORWARD_EN
    // Forward the stage result; hide the write enable until load data is ready.
    always_comb begin
        wreg_f  = wreg_o & ~stall_req_o;
        wd_f    = wd_o;
        wdata_f = wdata_o;
    end
`else
    // Forwarding disabled: ctrl stalls on every MEM-stage hazard.
    always_comb begin
        wreg_f  = 1'b0;
        wd_f    = 5'd0;
        wdata_f = 32'd0;
    end
`endif

endmodule

// File: tb/tb_mem.sv
// tb_mem: random and directed checks of the mem stage against a
// transaction-level model of byte-serialized loads and stores.
module tb_mem;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  aluop;
    logic [2:0]  f3;
    logic        me;
    logic [31:0] maddr;
    logic        wreg_i;
    logic [4:0]  wd_i;
    logic [31:0] wdata_i;
    logic [7:0]  din;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o, stall_req_o;
    logic        wreg_o, wreg_f;
    logic [4:0]  wd_o, wd_f;
    logic [31:0] wdata_o, wdata_f;

    always #5 clk = ~clk;

    mem #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .aluop_i(aluop), .alufunct3_i(f3), .me_i(me), .maddr_i(maddr),
        .wreg_i(wreg_i), .wd_i(wd_i), .wdata_i(wdata_i),
        .mem_din_i(din),
        .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o),
        .stall_req_o(stall_req_o),
        .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o),
        .wreg_f(wreg_f), .wd_f(wd_f), .wdata_f(wdata_f)
    );

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;

    logic [7:0] ram [logic [31:0]];
    logic [7:0] mdl [logic [31:0]];

    function automatic logic [7:0] init_b(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_b(a);
    endfunction

    function automatic logic [7:0] mdl_rd(logic [31:0] a);
        if (mdl.exists(a)) return mdl[a];
        return init_b(a);
    endfunction

    function automatic int nb(logic [2:0] fn);
        case (fn)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Byte-wide RAM with one-cycle read latency.
    always @(posedge clk) begin
        din <= ram_rd(mem_a_o);
        if (mem_wr_o) ram[mem_a_o] = mem_dout_o;
    end

    bit          e_on = 1'b0;
    bit          e_stall, e_wr, e_res, e_wreg;
    logic [31:0] e_a, e_wdata;
    logic [7:0]  e_dout;
    logic [4:0]  e_wd;
    logic [31:0] last_a = 32'd0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (e_on) begin
            if (stall_req_o) stall_cnt++;
            chk("stall", 32'(stall_req_o), 32'(e_stall));
            chk("wr", 32'(mem_wr_o), 32'(e_wr));
            chk("addr", mem_a_o, e_a);
            if (e_wr) chk("dout", 32'(mem_dout_o), 32'(e_dout));
            if (e_res) begin
                chk("wreg_o", 32'(wreg_o), 32'(e_wreg));
                chk("wd_o", 32'(wd_o), 32'(e_wd));
                chk("wdata_o", wdata_o, e_wdata);
            end
`ifdef MEM_FORWARD_EN
            if (e_stall) chk("wreg_f_stall", 32'(wreg_f), 32'd0);
            else if (e_res) begin
                chk("wreg_f", 32'(wreg_f), 32'(e_wreg));
                chk("wd_f", 32'(wd_f), 32'(e_wd));
                chk("wdata_f", wdata_f, e_wdata);
            end
`else
            chk("fwd_off", {wdata_f[25:0], wd_f, wreg_f}, 32'd0);
`endif
        end
    end

    task automatic ex(bit s, bit w, logic [31:0] a, logic [7:0] d,
                      bit r, bit wr, logic [4:0] wd, logic [31:0] wdv);
        e_stall = s; e_wr = w; e_a = a; e_dout = d;
        e_res = r; e_wreg = wr; e_wd = wd; e_wdata = wdv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        aluop = 7'($urandom); f3 = 3'($urandom); me = 1'($urandom);
        maddr = $urandom; wreg_i = 1'($urandom); wd_i = 5'($urandom);
        wdata_i = $urandom;
    endtask

    task automatic op_load(input logic [2:0] fn, input logic [31:0] a,
                           input bit wr, input logic [4:0] wd,
                           output logic [31:0] val);
        int n;
        n = nb(fn);
        val = 32'd0;
        for (int k = 0; k < n; k++)
            val = val | (32'(mdl_rd(a + 32'(k))) << (8 * k));
        if (fn == 3'b000 && val[7]) val = val | 32'hFFFFFF00;
        if (fn == 3'b001 && val[15]) val = val | 32'hFFFF0000;
        aluop = OP_LOAD; f3 = fn; me = 1'b1; maddr = a;
        wreg_i = wr; wd_i = wd; wdata_i = $urandom;
        for (int i = 0; i < n; i++) begin
            ex(1, 0, a + 32'(i), 8'h00, 0, 0, 5'd0, 32'd0);
            step();
            scramble();
        end
        ex(1, 0, a + 32'(n - 1), 8'h00, 0, 0, 5'd0, 32'd0);
        step();
        scramble();
        ex(0, 0, a + 32'(n - 1), 8'h00, 1, wr, wd, val);
        last_a = a + 32'(n - 1);
        step();
    endtask

    task automatic op_store(input logic [2:0] fn, input logic [31:0] a,
                            input logic [4:0] wd, input logic [31:0] d);
        int n;
        logic [7:0] b;
        n = nb(fn);
        aluop = OP_STORE; f3 = fn; me = 1'b1; maddr = a;
        wreg_i = 1'($urandom); wd_i = wd; wdata_i = d;
        for (int i = 0; i < n; i++) begin
            b = 8'(d >> (8 * i));
            mdl[a + 32'(i)] = b;
            ex(1, 1, a + 32'(i), b, 0, 0, 5'd0, 32'd0);
            step();
            scramble();
        end
        ex(0, 0, a + 32'(n - 1), 8'h00, 1, 0, wd, 32'd0);
        last_a = a + 32'(n - 1);
        step();
    endtask

    task automatic op_alu(input bit wr, input logic [4:0] wd,
                          input logic [31:0] v);
        aluop = OP_ALU; f3 = 3'($urandom); me = 1'b0; maddr = $urandom;
        wreg_i = wr; wd_i = wd; wdata_i = v;
        ex(0, 0, last_a, 8'h00, 1, wr, wd, v);
        step();
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        int kind;
        rst = 1'b0; aluop = 7'd0; f3 = 3'd0; me = 1'b0; maddr = 32'd0;
        wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'd0;
        ex(0, 0, 32'd0, 8'h00, 1, 0, 5'd0, 32'd0);
        e_on = 1'b1;
        step();
        step();
        rst = 1'b1;
        op_alu(0, 5'd0, 32'd0);

        ram[32'h100] = 8'h78; ram[32'h101] = 8'h56;
        ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
        mdl[32'h100] = 8'h78; mdl[32'h101] = 8'h56;
        mdl[32'h102] = 8'h34; mdl[32'h103] = 8'h12;
        ram[32'h300] = 8'h80; mdl[32'h300] = 8'h80;

        stall_cnt = 0;
        op_load(3'b010, 32'h100, 1, 5'd7, v);
        chk("lw_model", v, 32'h12345678);
        chk("lw_stall", 32'(stall_cnt), 32'd5);

        stall_cnt = 0;
        op_load(3'b000, 32'h300, 1, 5'd8, v);
        chk("lb_model", v, 32'hFFFFFF80);
        chk("lb_stall", 32'(stall_cnt), 32'd2);

        stall_cnt = 0;
        op_load(3'b100, 32'h300, 1, 5'd8, v);
        chk("lbu_model", v, 32'h00000080);
        chk("lbu_stall", 32'(stall_cnt), 32'd2);

        stall_cnt = 0;
        op_store(3'b001, 32'h201, 5'd9, 32'h1234ABCD);
        chk("sh_stall", 32'(stall_cnt), 32'd2);
        chk("sh_b0", 32'(ram_rd(32'h201)), 32'h0CD);
        chk("sh_b1", 32'(ram_rd(32'h202)), 32'h0AB);
        chk("sh_b2", 32'(ram_rd(32'h203)), 32'h0A4);

        stall_cnt = 0;
        op_alu(1, 5'd5, 32'd7);
        chk("addi_stall", 32'(stall_cnt), 32'd0);

        op_load(3'b010, 32'hFFFFFFFE, 1, 5'd3, v);
        chk("lw_wrap_model", v, 32'hA4A5A5A4);

        aluop = OP_STORE; f3 = 3'b010; me = 1'b1; maddr = 32'h500;
        wreg_i = 1'b0; wd_i = 5'd1; wdata_i = 32'hDEADBEEF;
        ex(1, 1, 32'h500, 8'hEF, 0, 0, 5'd0, 32'd0);
        mdl[32'h500] = 8'hEF;
        step();
        scramble();
        ex(1, 1, 32'h501, 8'hBE, 0, 0, 5'd0, 32'd0);
        mdl[32'h501] = 8'hBE;
        step();
        rst = 1'b0;
        ex(0, 0, 32'd0, 8'h00, 1, 0, 5'd0, 32'd0);
        step();
        rst = 1'b1; me = 1'b0; wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'd0;
        ex(0, 0, 32'd0, 8'h00, 1, 0, 5'd0, 32'd0);
        last_a = 32'd0;
        step();
        op_load(3'b010, 32'h500, 1, 5'd4, v);
        chk("rst_lw_model", v, 32'hA3A2BEEF);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0)
                a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else
                a = 32'h400 + 32'($urandom_range(0, 15));
            case (kind)
                0: op_load(3'($urandom), a, 1'($urandom), 5'($urandom), v);
                1: op_store(3'($urandom_range(0, 3)), a, 5'($urandom), $urandom);
                default: op_alu(1'($urandom), 5'($urandom), $urandom);
            endcase
        end

        e_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
